// File: rtl/c17_bist_ctrl.sv
// BIST wrapper for the c17 netlist: a 5-bit LFSR drives the netlist inputs,
// and a 16-bit MISR compacts the outputs into a signature that is checked against a golden value.
module c17_bist_ctrl #(
   parameter int unsigned NUM_PATTERNS  = 31,
   parameter int unsigned SETTLE_CYCLES = 12,
   parameter logic [4:0]  LFSR_SEED     = 5'b00001,
   parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [4:0]  pi_out,
   input  logic [1:0]  po_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature,
   output logic [4:0]  pattern_cnt
);

   localparam int unsigned CNT_W       = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [4:0]  LAST_PAT    = 5'(NUM_PATTERNS);
   // The LFSR locks up at zero, so a zero seed is replaced with 1.
   localparam logic [4:0]  SEED_EFF    = (LFSR_SEED == 5'd0) ? 5'd1 : LFSR_SEED;

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   settle_cnt;
   logic [15:0]        misr_next;

   // MISR polynomial taps 15,14,12,3; the netlist outputs are folded into the low two bits.
   function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [1:0] po);
      logic fb;
      fb = m[15] ^ m[14] ^ m[12] ^ m[3];
      return {m[14:0], fb} ^ {14'b0, po};
   endfunction

   function automatic logic [4:0] lfsr_step(input logic [4:0] l);
      return {l[3:0], l[4] ^ l[2]};
   endfunction

   assign misr_next = misr_step(signature, po_in);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pi_out      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         signature   <= '0;
         pattern_cnt <= '0;
         settle_cnt  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  pi_out      <= SEED_EFF;
                  signature   <= '0;
                  pattern_cnt <= '0;
                  settle_cnt  <= '0;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  busy        <= 1'b1;
                  state       <= SETTLE;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 1'b1;
               if (settle_cnt == SETTLE_LAST) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               signature   <= misr_next;
               pattern_cnt <= pattern_cnt + 5'd1;
               if (pattern_cnt + 5'd1 == LAST_PAT) begin
                  done  <= 1'b1;
                  pass  <= (misr_next == GOLDEN_SIG);
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  pi_out     <= lfsr_step(pi_out);
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Scoreboard bench for c17_bist_ctrl: four instances with different parameters,
// each driving a behavioural c17 netlist. Completed runs are checked against queued expectations.
module tb_c17_bist_ctrl;

   typedef struct {
      int          cyc;
      logic [15:0] sig;
      logic [4:0]  cnt;
      logic        pass;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t sb [4][$];

   logic rst_a = 1'b1, rst_o = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
   logic [4:0]  pi_a, pi_b, pi_c, pi_d;
   logic [1:0]  po_a, po_b, po_c, po_d;
   logic        busy_a, busy_b, busy_c, busy_d;
   logic        done_a, done_b, done_c, done_d;
   logic        pass_a, pass_b, pass_c, pass_d;
   logic [15:0] sig_a, sig_b, sig_c, sig_d;
   logic [4:0]  cnt_a, cnt_b, cnt_c, cnt_d;

   function automatic logic [1:0] c17(input logic [4:0] p);
      logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
      {n1, n2, n3, n6, n7} = p;
      n10 = ~(n1 & n3);
      n11 = ~(n3 & n6);
      n16 = ~(n2 & n11);
      n19 = ~(n11 & n7);
      return {~(n10 & n16), ~(n16 & n19)};
   endfunction

   assign po_a = c17(pi_a);
   assign po_b = c17(pi_b);
   assign po_c = c17(pi_c);
   assign po_d = c17(pi_d);

   c17_bist_ctrl #(.NUM_PATTERNS(2), .SETTLE_CYCLES(12), .LFSR_SEED(5'b00001), .GOLDEN_SIG(16'h0002)) u_a (
      .clk(clk), .rst(rst_a), .start(start_a), .pi_out(pi_a), .po_in(po_a), .busy(busy_a),
      .done(done_a), .pass(pass_a), .signature(sig_a), .pattern_cnt(cnt_a));
   c17_bist_ctrl #(.NUM_PATTERNS(1), .SETTLE_CYCLES(12), .LFSR_SEED(5'b00001), .GOLDEN_SIG(16'h0000)) u_b (
      .clk(clk), .rst(rst_o), .start(start_b), .pi_out(pi_b), .po_in(po_b), .busy(busy_b),
      .done(done_b), .pass(pass_b), .signature(sig_b), .pattern_cnt(cnt_b));
   c17_bist_ctrl #(.NUM_PATTERNS(2), .SETTLE_CYCLES(12), .LFSR_SEED(5'b00001), .GOLDEN_SIG(16'h0003)) u_c (
      .clk(clk), .rst(rst_o), .start(start_c), .pi_out(pi_c), .po_in(po_c), .busy(busy_c),
      .done(done_c), .pass(pass_c), .signature(sig_c), .pattern_cnt(cnt_c));
   c17_bist_ctrl #(.NUM_PATTERNS(31), .SETTLE_CYCLES(12), .LFSR_SEED(5'b00000), .GOLDEN_SIG(16'h0000)) u_d (
      .clk(clk), .rst(rst_o), .start(start_d), .pi_out(pi_d), .po_in(po_d), .busy(busy_d),
      .done(done_d), .pass(pass_d), .signature(sig_d), .pattern_cnt(cnt_d));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic mon(input int id, input logic [15:0] sig, input logic [4:0] cnt, input logic pass);
      exp_t e;
      if (sb[id].size() == 0) begin
         chk($sformatf("unexpected_done_%0d", id), 1, 0);
      end else begin
         e = sb[id].pop_front();
         chk($sformatf("done_cycle_%0d", id), cyc, e.cyc);
         chk($sformatf("signature_%0d", id), sig, e.sig);
         chk($sformatf("pattern_cnt_%0d", id), cnt, e.cnt);
         chk($sformatf("pass_%0d", id), pass, e.pass);
      end
   endtask

   // Monitor: a rising done is the DUT presenting a finished run.
   logic pd_a = 1'b0, pd_b = 1'b0, pd_c = 1'b0, pd_d = 1'b0;
   always @(negedge clk) begin
      if (done_a && !pd_a) mon(0, sig_a, cnt_a, pass_a);
      if (done_b && !pd_b) mon(1, sig_b, cnt_b, pass_b);
      if (done_c && !pd_c) mon(2, sig_c, cnt_c, pass_c);
      if (done_d && !pd_d) mon(3, sig_d, cnt_d, pass_d);
      pd_a <= done_a;
      pd_b <= done_b;
      pd_c <= done_c;
      pd_d <= done_d;
   end

   // Track the distinct patterns applied by the 31-pattern instance.
   logic [31:0] seen = '0;
   logic [4:0]  prev_pi_d = '0;
   int          distinct = 0;
   int          repeats = 0;
   always @(negedge clk) begin
      if (busy_d && pi_d != prev_pi_d) begin
         if (seen[pi_d]) repeats++;
         else distinct++;
         seen[pi_d] = 1'b1;
      end
      prev_pi_d <= pi_d;
   end

   function automatic logic [15:0] model_sig(input int np, input logic [4:0] seed);
      logic [4:0]  l;
      logic [15:0] m;
      logic [1:0]  po;
      l = (seed == 5'd0) ? 5'd1 : seed;
      m = '0;
      for (int i = 0; i < np; i++) begin
         po = c17(l);
         m = {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {14'b0, po};
         l = {l[3:0], l[4] ^ l[2]};
      end
      return m;
   endfunction

   task automatic push(input int id, input int dcyc, input logic [15:0] s, input logic [4:0] c,
                       input logic p);
      exp_t e;
      e.cyc = dcyc;
      e.sig = s;
      e.cnt = c;
      e.pass = p;
      sb[id].push_back(e);
   endtask

   task automatic wait_done_a(input int lim);
      int k;
      k = 0;
      while (!done_a && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk("wait_done_a", done_a, 1);
   endtask

   initial begin
      logic [15:0] sd;
      int acc;
      int k;
      repeat (2) @(negedge clk);
      chk("rst_pi", pi_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_pass", pass_a, 0);
      chk("rst_sig", sig_a, 0);
      chk("rst_cnt", cnt_a, 0);
      rst_a = 1'b0;
      rst_o = 1'b0;

      // All four instances start on the same edge.
      @(negedge clk);
      start_a = 1'b1; start_b = 1'b1; start_c = 1'b1; start_d = 1'b1;
      acc = cyc + 1;
      sd = model_sig(31, 5'd0);
      push(0, acc + 26, 16'h0002, 5'd2, 1'b1);
      push(1, acc + 13, 16'h0001, 5'd1, 1'b0);
      push(2, acc + 26, 16'h0002, 5'd2, 1'b0);
      push(3, acc + 31 * 13, sd, 5'd31, sd == 16'h0000);
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
      chk("first_pi", pi_a, 5'b00001);
      chk("first_busy", busy_a, 1);
      chk("first_done", done_a, 0);
      chk("zero_seed_pi", pi_d, 5'b00001);

      // Start pulses while running must be ignored.
      repeat (4) @(negedge clk);
      start_a = 1'b1; start_d = 1'b1;
      @(negedge clk);
      start_a = 1'b0; start_d = 1'b0;
      repeat (12) @(negedge clk);
      chk("second_pi", pi_a, 5'b00010);

      wait_done_a(60);
      @(negedge clk);
      start_a = 1'b1;
      push(0, cyc + 1 + 26, 16'h0002, 5'd2, 1'b1);
      @(negedge clk);
      start_a = 1'b0;
      chk("restart_done_drop", done_a, 0);
      chk("restart_busy", busy_a, 1);
      chk("restart_pi", pi_a, 5'b00001);
      chk("restart_sig", sig_a, 0);

      // Abort with reset at the fifth SETTLE edge; no result is expected.
      wait_done_a(60);
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (4) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      chk("abort_pi", pi_a, 0);
      chk("abort_busy", busy_a, 0);
      chk("abort_done", done_a, 0);
      chk("abort_pass", pass_a, 0);
      chk("abort_sig", sig_a, 0);
      chk("abort_cnt", cnt_a, 0);

      @(negedge clk);
      start_a = 1'b1;
      push(0, cyc + 1 + 26, 16'h0002, 5'd2, 1'b1);
      @(negedge clk);
      start_a = 1'b0;

      k = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("pending_%0d", i), sb[i].size(), 0);
      chk("distinct_patterns", distinct, 31);
      chk("repeated_patterns", repeats, 0);
      chk("final_cnt_d", cnt_d, 5'd31);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
